// File: rtl/ecall_pkg.sv
// Shared definitions for the ecall/halt controller: operand-forward select codes
// and the halt FSM state encoding.
package ecall_pkg;

  // Source selects for the ID ecall operand mux
  localparam logic [1:0] FWD_RF  = 2'b00;  // register-file read
  localparam logic [1:0] FWD_MEM = 2'b01;  // EX/MEM alu_out
  localparam logic [1:0] FWD_WB  = 2'b10;  // WB rd_din

  // Halt sequencing: normal execution, draining older instructions, halted (absorbing)
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

endpackage : ecall_pkg

// File: rtl/ecall_dep_check.sv
// Dependency check for the ecall argument register in ID against the in-flight
// writers in EX, MEM and WB. Pure combinational; the youngest matching writer wins.
// A value still being produced (EX result, MEM load) cannot be forwarded and stalls.
module ecall_dep_check
  import ecall_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int ECALL_REG = 17
) (
  input  logic              check_en,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        fwd_sel,
  output logic              dep_stall
);

  localparam logic [REG_AW-1:0] TGT = REG_AW'(ECALL_REG);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  // x0 is hardwired zero, so a write targeting it never produces a dependency
  assign ex_hit  = ex_reg_write  && (ex_rd  == TGT) && (ex_rd  != '0);
  assign mem_hit = mem_reg_write && (mem_rd == TGT) && (mem_rd != '0);
  assign wb_hit  = wb_reg_write  && (wb_rd  == TGT) && (wb_rd  != '0);

  // Priority resolution, youngest stage first
  always_comb begin
    // NOTE: every output gets a default before the if-chain so no path leaves it unassigned (no latch).
    fwd_sel   = FWD_RF;
    dep_stall = 1'b0;
    if (check_en) begin
      if (ex_hit) begin
        dep_stall = 1'b1;
      end else if (mem_hit && mem_mem_read) begin
        dep_stall = 1'b1;
      end else if (mem_hit) begin
        fwd_sel = FWD_MEM;
      end else if (wb_hit) begin
        fwd_sel = FWD_WB;
      end
    end
  end

endmodule : ecall_dep_check

// File: rtl/ecall_halt_ctrl.sv
// Ecall control beside the hazard unit: resolves the ecall argument operand
// (forward / stall / register file) and, on a halt-valued ecall, freezes fetch,
// drains the older instructions for DRAIN_CYCLES and then raises a sticky halt.
// Optional build macro: ECALL_STATS_EN adds saturating ecall_cnt / stall_cnt counters.
module ecall_halt_ctrl
  import ecall_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int REG_AW       = 5,
  parameter int ECALL_REG    = 17,
  parameter int HALT_VALUE   = 10,
  parameter int DRAIN_CYCLES = 3,
  parameter int STAT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              id_is_ecall,
  input  logic [XLEN-1:0]   id_rf_data,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_alu_out,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_rd_din,
  output logic [1:0]        ecall_fwd_sel,
  output logic [XLEN-1:0]   ecall_operand,
  output logic              ecall_stall,
  output logic              fetch_freeze,
  output logic              is_halted
`ifdef ECALL_STATS_EN
  ,
  output logic [STAT_W-1:0] ecall_cnt,
  output logic [STAT_W-1:0] stall_cnt
`endif
);

  // Drain counter only has to hold DRAIN_CYCLES-1
  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ecall_req;
  logic dep_stall;
  logic halt_fire;

  assign ecall_req = id_valid && id_is_ecall;

  ecall_dep_check #(
    .REG_AW    (REG_AW),
    .ECALL_REG (ECALL_REG)
  ) u_dep_check (
    .check_en      (ecall_req),
    .ex_reg_write  (ex_reg_write),
    .ex_rd         (ex_rd),
    .mem_reg_write (mem_reg_write),
    .mem_mem_read  (mem_mem_read),
    .mem_rd        (mem_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .fwd_sel       (ecall_fwd_sel),
    .dep_stall     (dep_stall)
  );

  // Operand mux driven by the forward select
  always_comb begin
    case (ecall_fwd_sel)
      FWD_MEM: ecall_operand = mem_alu_out;
      FWD_WB:  ecall_operand = wb_rd_din;
      default: ecall_operand = id_rf_data;
    endcase
  end

  // Once fetch is frozen the pipeline no longer advances, so a stall is meaningless
  assign ecall_stall  = (state_q == ST_RUN) && dep_stall;
  assign halt_fire    = (state_q == ST_RUN) && ecall_req && !ecall_stall &&
                        (ecall_operand == XLEN'(HALT_VALUE));
  assign fetch_freeze = halt_fire || (state_q != ST_RUN);
  assign is_halted    = (state_q == ST_HALTED);

  // Halt FSM next-state and drain counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (halt_fire) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = ST_HALTED;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // FSM and drain counter registers, synchronous reset has priority
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ECALL_STATS_EN
  logic [STAT_W-1:0] ecall_cnt_q, ecall_cnt_d;
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating event counters
  always_comb begin
    ecall_cnt_d = ecall_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (ecall_req && !ecall_stall && (state_q == ST_RUN) && (ecall_cnt_q != '1)) begin
      ecall_cnt_d = ecall_cnt_q + 1'b1;
    end
    if (ecall_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ecall_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      ecall_cnt_q <= ecall_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ecall_cnt = ecall_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule : ecall_halt_ctrl

// File: tb/tb_ecall_halt_ctrl.sv
// Self-checking bench for ecall_halt_ctrl: directed scenarios followed by random
// traffic, all compared against a behavioural model of the ecall/halt rules.
// Build with ECALL_STATS_EN defined to also check the saturating counters (STAT_W=2).
module tb_ecall_halt_ctrl;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int EREG   = 17;
  localparam int HALTV  = 10;
  localparam int DRAIN  = 3;
`ifdef ECALL_STATS_EN
  localparam int TB_STAT_W = 2;
`else
  localparam int TB_STAT_W = 16;
`endif
  localparam int STAT_MAX = (1 << TB_STAT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid, id_is_ecall;
  logic [XLEN-1:0]   id_rf_data;
  logic              ex_reg_write;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_reg_write, mem_mem_read;
  logic [REG_AW-1:0] mem_rd;
  logic [XLEN-1:0]   mem_alu_out;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_rd_din;
  logic [1:0]        ecall_fwd_sel;
  logic [XLEN-1:0]   ecall_operand;
  logic              ecall_stall, fetch_freeze, is_halted;
`ifdef ECALL_STATS_EN
  logic [TB_STAT_W-1:0] ecall_cnt, stall_cnt;
`endif

  ecall_halt_ctrl #(
    .XLEN(XLEN), .REG_AW(REG_AW), .ECALL_REG(EREG), .HALT_VALUE(HALTV),
    .DRAIN_CYCLES(DRAIN), .STAT_W(TB_STAT_W)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_is_ecall(id_is_ecall),
    .id_rf_data(id_rf_data), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
    .mem_alu_out(mem_alu_out), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_rd_din(wb_rd_din), .ecall_fwd_sel(ecall_fwd_sel), .ecall_operand(ecall_operand),
    .ecall_stall(ecall_stall), .fetch_freeze(fetch_freeze), .is_halted(is_halted)
`ifdef ECALL_STATS_EN
    , .ecall_cnt(ecall_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: cycle index, cycle of the accepted halt ecall, event counts
  int cyc      = 0;
  int fire_cyc = -1;
  int e_model  = 0;
  int s_model  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Writers listed youngest first; the first one writing the argument register decides
  function automatic void dep_model(output logic [1:0] sel, output logic stall);
    logic we [3];
    int   rd [3];
    we = '{ex_reg_write, mem_reg_write, wb_reg_write};
    rd = '{int'(ex_rd), int'(mem_rd), int'(wb_rd)};
    sel   = 2'd0;
    stall = 1'b0;
    if (!(id_valid && id_is_ecall)) return;
    for (int i = 0; i < 3; i++) begin
      if (we[i] && rd[i] == EREG && rd[i] != 0) begin
        if (i == 0 || (i == 1 && mem_mem_read)) stall = 1'b1;
        else sel = 2'(i);
        return;
      end
    end
  endfunction

  // Compare all outputs with the model for the current cycle, then advance one clock
  task automatic tick();
    logic [1:0]  sel_e;
    logic        stall_e, in_run, fire_e, freeze_e, halted_e;
    logic [31:0] op_e;
    #2;
    dep_model(sel_e, stall_e);
    in_run   = (fire_cyc < 0);
    stall_e  = stall_e && in_run;
    op_e     = (sel_e == 2'd1) ? mem_alu_out : (sel_e == 2'd2) ? wb_rd_din : id_rf_data;
    fire_e   = in_run && id_valid && id_is_ecall && !stall_e && (op_e == 32'(HALTV));
    freeze_e = fire_e || !in_run;
    halted_e = (fire_cyc >= 0) && (cyc >= fire_cyc + DRAIN + 1);
    chk("m_stall", 32'(ecall_stall), 32'(stall_e));
    chk("m_freeze", 32'(fetch_freeze), 32'(freeze_e));
    chk("m_halted", 32'(is_halted), 32'(halted_e));
    if (!stall_e) begin
      chk("m_sel", 32'(ecall_fwd_sel), 32'(sel_e));
      chk("m_operand", ecall_operand, op_e);
    end
`ifdef ECALL_STATS_EN
    chk("m_ecall_cnt", 32'(ecall_cnt), 32'(e_model));
    chk("m_stall_cnt", 32'(stall_cnt), 32'(s_model));
`endif
    if (reset) begin
      fire_cyc = -1;
      e_model  = 0;
      s_model  = 0;
    end else begin
      if (fire_e) fire_cyc = cyc;
      if (in_run && id_valid && id_is_ecall && !stall_e && e_model < STAT_MAX) e_model++;
      if (stall_e && s_model < STAT_MAX) s_model++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_is_ecall = 0; id_rf_data = '0;
    ex_reg_write = 0; ex_rd = '0;
    mem_reg_write = 0; mem_mem_read = 0; mem_rd = '0; mem_alu_out = '0;
    wb_reg_write = 0; wb_rd = '0; wb_rd_din = '0;
  endtask

  task automatic ecall(input logic [31:0] rf);
    idle();
    id_valid = 1; id_is_ecall = 1; id_rf_data = rf;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    @(posedge clk);
    #1;
    tick();
    reset = 0;
    // Reset state
    #1;
    chk("rst_halted", 32'(is_halted), 32'd0);
    chk("rst_freeze", 32'(fetch_freeze), 32'd0);

    // 1: no writers, argument from the register file, never halts
    ecall(32'd5);
    #1;
    chk("t1_sel", 32'(ecall_fwd_sel), 32'd0);
    chk("t1_operand", ecall_operand, 32'd5);
    chk("t1_stall", 32'(ecall_stall), 32'd0);
    chk("t1_freeze", 32'(fetch_freeze), 32'd0);
    tick();
    idle();
    repeat (5) tick();
    chk("t1_not_halted", 32'(is_halted), 32'd0);

    // 2: EX writer stalls, then forwarded from MEM with the halt value
    ecall(32'd0); ex_reg_write = 1; ex_rd = 5'(EREG);
    #1;
    chk("t2_ex_stall", 32'(ecall_stall), 32'd1);
    tick();
    ecall(32'd0); mem_reg_write = 1; mem_rd = 5'(EREG); mem_alu_out = 32'(HALTV);
    #1;
    chk("t2_sel", 32'(ecall_fwd_sel), 32'd1);
    chk("t2_fire_freeze", 32'(fetch_freeze), 32'd1);
    tick();
    idle();
    for (int i = 0; i < DRAIN; i++) begin
      chk("t2_drain_halted", 32'(is_halted), 32'd0);
      chk("t2_drain_freeze", 32'(fetch_freeze), 32'd1);
      tick();
    end
    chk("t2_halted", 32'(is_halted), 32'd1);
    repeat (3) tick();
    chk("t2_sticky", 32'(is_halted), 32'd1);
    do_reset();

    // 3: MEM load stalls, then WB supplies the halt value
    ecall(32'd0); mem_reg_write = 1; mem_mem_read = 1; mem_rd = 5'(EREG);
    #1;
    chk("t3_load_stall", 32'(ecall_stall), 32'd1);
    tick();
    ecall(32'd0); wb_reg_write = 1; wb_rd = 5'(EREG); wb_rd_din = 32'(HALTV);
    #1;
    chk("t3_sel", 32'(ecall_fwd_sel), 32'd2);
    tick();
    idle();
    repeat (DRAIN) tick();
    chk("t3_halted", 32'(is_halted), 32'd1);
    do_reset();

    // 4: MEM is younger than WB and wins
    ecall(32'd0);
    mem_reg_write = 1; mem_rd = 5'(EREG); mem_alu_out = 32'd3;
    wb_reg_write = 1; wb_rd = 5'(EREG); wb_rd_din = 32'(HALTV);
    #1;
    chk("t4_sel", 32'(ecall_fwd_sel), 32'd1);
    chk("t4_operand", ecall_operand, 32'd3);
    chk("t4_no_freeze", 32'(fetch_freeze), 32'd0);
    tick();
    // writes to x0 never match
    ecall(32'd4); ex_reg_write = 1; ex_rd = '0;
    #1;
    chk("t4_x0_stall", 32'(ecall_stall), 32'd0);
    tick();
    idle();
    repeat (5) tick();
    chk("t4_not_halted", 32'(is_halted), 32'd0);

    // 5: reset in the second drain cycle, then a normal halt
    ecall(32'(HALTV));
    tick();
    idle();
    tick();
    reset = 1;
    tick();
    reset = 0;
    chk("t5_freeze", 32'(fetch_freeze), 32'd0);
    chk("t5_halted", 32'(is_halted), 32'd0);
    ecall(32'(HALTV));
    tick();
    idle();
    repeat (DRAIN) tick();
    chk("t5_rehalt", 32'(is_halted), 32'd1);
    do_reset();

    // 6: statistics (3 ecalls, 2 stall cycles), then saturation
    ecall(32'd5); ex_reg_write = 1; ex_rd = 5'(EREG);
    tick();
    ecall(32'd5);
    tick();
    ecall(32'd5); mem_reg_write = 1; mem_mem_read = 1; mem_rd = 5'(EREG);
    tick();
    ecall(32'd5); mem_reg_write = 1; mem_rd = 5'(EREG); mem_alu_out = 32'd5;
    tick();
    ecall(32'd5);
    tick();
    idle();
    tick();
`ifdef ECALL_STATS_EN
    chk("t6_ecall_cnt", 32'(ecall_cnt), 32'd3);
    chk("t6_stall_cnt", 32'(stall_cnt), 32'd2);
`endif
    ecall(32'd5);
    repeat (5) tick();
    idle();
    tick();
`ifdef ECALL_STATS_EN
    chk("t6_ecall_sat", 32'(ecall_cnt), 32'(STAT_MAX));
`endif
    do_reset();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      int pick;
      idle();
      id_valid     = 1'($urandom_range(0, 3) != 0);
      id_is_ecall  = 1'($urandom_range(0, 2) != 0);
      id_rf_data   = ($urandom_range(0, 3) == 0) ? 32'(HALTV) : 32'($urandom_range(0, 15));
      ex_reg_write = 1'($urandom_range(0, 3) == 0);
      mem_reg_write = 1'($urandom_range(0, 2) == 0);
      mem_mem_read = 1'($urandom_range(0, 2) == 0);
      wb_reg_write = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 3);
      ex_rd  = (pick == 0) ? 5'(EREG) : (pick == 1) ? 5'd0 : 5'($urandom);
      pick = $urandom_range(0, 2);
      mem_rd = (pick == 0) ? 5'(EREG) : (pick == 1) ? 5'd0 : 5'($urandom);
      pick = $urandom_range(0, 2);
      wb_rd  = (pick == 0) ? 5'(EREG) : (pick == 1) ? 5'd0 : 5'($urandom);
      mem_alu_out = ($urandom_range(0, 2) == 0) ? 32'(HALTV) : 32'($urandom);
      wb_rd_din   = ($urandom_range(0, 2) == 0) ? 32'(HALTV) : 32'($urandom);
      reset = ((fire_cyc >= 0) && (cyc > fire_cyc + DRAIN + 3)) ||
              ($urandom_range(0, 49) == 0);
      tick();
    end
    reset = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ecall_halt_ctrl
